// File: rtl/jt12_slot_pkg.sv
// jt12_slot_pkg: shared slot constants, write-arbiter states and slot helpers
package jt12_slot_pkg;
   localparam int SLOTS     = 24;
   localparam int OPS       = 4;
   localparam int CH_PER_OP = 6;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic [4:0] slot_of(input logic [2:0] ch, input logic [1:0] op);
      return {1'b0, op, 2'b00} + {2'b00, op, 1'b0} + (ch[2] ? 5'd3 : 5'd0) + {3'b000, ch[1:0]};
   endfunction

   function automatic logic ch_valid(input logic [2:0] ch);
      return ch[1:0] != 2'd3;
   endfunction
endpackage

// File: rtl/jt12_slot_cnt.sv
// jt12_slot_cnt: clk_en-gated mod-24 slot counter with channel/operator decode
module jt12_slot_cnt
   import jt12_slot_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   output logic [4:0] slot,
   output logic [1:0] cur_op,
   output logic [2:0] cur_ch,
   output logic       zero
);
   logic [4:0] k;

   // advance one slot per enabled clock, wrapping after the last slot
   always_ff @(posedge clk or posedge rst)
      if (rst) slot <= 5'd0;
      else if (clk_en) slot <= (slot == 5'(SLOTS - 1)) ? 5'd0 : slot + 5'd1;

   // operator is the slot's group of six; channel is {upper half, index within half}
   always_comb begin
      cur_op = (slot >= 5'((OPS - 1) * CH_PER_OP)) ? 2'd3 :
               (slot >= 5'(2 * CH_PER_OP))         ? 2'd2 :
               (slot >= 5'(CH_PER_OP))             ? 2'd1 : 2'd0;
      k      = slot - slot_of(3'd0, cur_op);
      cur_ch = (k >= 5'd3) ? {1'b1, k[1:0] + 2'd1} : {1'b0, k[1:0]};
      zero   = slot == 5'd0;
   end
endmodule

// File: rtl/jt12_slot_sched.sv
// jt12_slot_sched: slot sequencer and write arbiter for the 24-stage operator register
module jt12_slot_sched
   import jt12_slot_pkg::*;
#(
   parameter int width = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic [width-1:0] fb_din,
   output logic [width-1:0] sh_din,
   output logic [4:0]       slot,
   output logic [1:0]       cur_op,
   output logic [2:0]       cur_ch,
   output logic             zero,
   input  logic             wr_req,
   input  logic [2:0]       wr_ch,
   input  logic [1:0]       wr_op,
   input  logic [width-1:0] wr_data,
   output logic             wr_busy,
   output logic             wr_ack,
   output logic             wr_err
);
   state_t           state, state_nx;
   logic [2:0]       ch_q;
   logic [1:0]       op_q;
   logic [width-1:0] data_q;
   logic             armed;
   logic             hit;

   jt12_slot_cnt u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .slot   (slot),
      .cur_op (cur_op),
      .cur_ch (cur_ch),
      .zero   (zero)
   );

   // armed stays low after a same-slot capture until the counter has moved, forcing a full revolution
   assign hit    = state == ST_WAIT && armed && slot == slot_of(ch_q, op_q);
   assign sh_din = (state == ST_INIT) ? '0 : hit ? data_q : fb_din;

   // next-state selection; only the flush end and the injection wait on clk_en
   always_comb begin
      state_nx = state;
      case (state)
         ST_INIT: state_nx = (clk_en && slot == 5'(SLOTS - 1)) ? ST_IDLE : ST_INIT;
         ST_IDLE: state_nx = (wr_req && ch_valid(wr_ch)) ? ST_WAIT : ST_IDLE;
         ST_WAIT: state_nx = (clk_en && hit) ? ST_DONE : ST_WAIT;
         default: state_nx = ST_IDLE;
      endcase
   end

   // state, registered status pulses and request capture
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= ST_INIT;
         wr_busy <= 1'b1;
         wr_ack  <= 1'b0;
         wr_err  <= 1'b0;
         ch_q    <= 3'd0;
         op_q    <= 2'd0;
         data_q  <= '0;
         armed   <= 1'b0;
      end else begin
         state   <= state_nx;
         wr_busy <= state_nx != ST_IDLE;
         wr_ack  <= state_nx == ST_DONE;
         wr_err  <= state == ST_IDLE && wr_req && !ch_valid(wr_ch);
         if (state == ST_IDLE && state_nx == ST_WAIT) begin
            ch_q   <= wr_ch;
            op_q   <= wr_op;
            data_q <= wr_data;
            armed  <= slot_of(wr_ch, wr_op) != slot;
         end else if (clk_en) armed <= 1'b1;
      end
endmodule

// File: tb/tb_jt12_slot_sched.sv
// tb_jt12_slot_sched: directed scoreboard bench with a 24-stage register closing the feedback loop
module tb_jt12_slot_sched;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk_en = 1'b1;
   logic [4:0] fb_din, sh_din, wr_data = 5'd0, fb_drv = 5'h1F;
   logic [4:0] slot;
   logic [1:0] cur_op, wr_op = 2'd0;
   logic [2:0] cur_ch, wr_ch = 3'd0;
   logic       zero, wr_req = 1'b0, wr_busy, wr_ack, wr_err;
   logic       loop = 1'b0;
   logic [4:0] sr [24];
   logic [4:0] regv [24];
   logic [4:0] eslot = 5'd0;
   int         checks = 0, errors = 0;

   typedef struct {
      logic [4:0] slot;
      logic [4:0] sh;
      logic       busy, ack, err;
   } rec_t;
   rec_t cyc_q[$];

   jt12_slot_sched #(.width(5)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .fb_din(fb_din), .sh_din(sh_din),
      .slot(slot), .cur_op(cur_op), .cur_ch(cur_ch), .zero(zero),
      .wr_req(wr_req), .wr_ch(wr_ch), .wr_op(wr_op), .wr_data(wr_data),
      .wr_busy(wr_busy), .wr_ack(wr_ack), .wr_err(wr_err)
   );

   always #5 clk = ~clk;

   assign fb_din = loop ? sr[23] : fb_drv;

   // the served shift register: stage 24 feeds back to fb_din
   always @(posedge clk)
      if (clk_en) begin
         for (int i = 23; i > 0; i--) sr[i] <= sr[i-1];
         sr[0] <= sh_din;
      end

   task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
      end
   endtask

   // monitor: pops one expected record per presented cycle and compares
   always @(negedge clk)
      if (cyc_q.size() != 0) begin
         rec_t r;
         int   s, k;
         r = cyc_q.pop_front();
         s = int'(r.slot);
         k = s % 6;
         chk("slot", 8'(slot), 8'(r.slot));
         chk("cur_op", 8'(cur_op), 8'(s / 6));
         chk("cur_ch", 8'(cur_ch), 8'((k >= 3 ? 4 : 0) + k % 3));
         chk("zero", 8'(zero), 8'(s == 0));
         chk("sh_din", 8'(sh_din), 8'(r.sh));
         chk("wr_busy", 8'(wr_busy), 8'(r.busy));
         chk("wr_ack", 8'(wr_ack), 8'(r.ack));
         chk("wr_err", 8'(wr_err), 8'(r.err));
      end

   task automatic step(input logic en, input logic req, input logic [2:0] ch, input logic [1:0] op,
                       input logic [4:0] d, input logic [4:0] esh, input logic eb, input logic ea,
                       input logic ee);
      clk_en  = en;
      wr_req  = req;
      wr_ch   = ch;
      wr_op   = op;
      wr_data = d;
      cyc_q.push_back('{eslot, esh, eb, ea, ee});
      @(posedge clk);
      if (en) eslot = (eslot == 5'd23) ? 5'd0 : eslot + 5'd1;
      #1;
   endtask

   task automatic run(input logic eb);
      step(1'b1, 1'b0, 3'd0, 2'd0, 5'd0, regv[eslot], eb, 1'b0, 1'b0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      foreach (regv[i]) regv[i] = 5'd0;
      @(posedge clk); #1;
      step(1'b1, 1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      eslot = 5'd0;
      rst = 1'b0;
      // flush: 24 zero slots, request in the middle must be ignored
      for (int i = 0; i < 24; i++)
         step(1'b1, i == 5, 3'd1, 2'd1, 5'h1B, 5'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 5'h1F, 1'b0, 1'b0, 1'b0);
      loop = 1'b1;
      // write ch5 op2 captured at slot 2 -> target 16
      run(1'b0);
      run(1'b0);
      step(1'b1, 1'b1, 3'd5, 2'd2, 5'h0A, 5'd0, 1'b0, 1'b0, 1'b0);
      wr_ch = 3'd0;
      while (eslot != 5'd16) run(1'b1);
      step(1'b1, 1'b0, 3'd0, 2'd0, 5'd0, 5'h0A, 1'b1, 1'b0, 1'b0);
      regv[16] = 5'h0A;
      step(1'b1, 1'b1, 3'd4, 2'd1, 5'h13, regv[eslot], 1'b1, 1'b1, 1'b0);
      // same-slot request at slot 18 with clk_en low for 10 clocks
      step(1'b0, 1'b1, 3'd0, 2'd3, 5'h15, regv[18], 1'b0, 1'b0, 1'b0);
      repeat (9) step(1'b0, 1'b0, 3'd0, 2'd0, 5'd0, regv[18], 1'b1, 1'b0, 1'b0);
      run(1'b1);
      while (eslot != 5'd18) run(1'b1);
      step(1'b1, 1'b0, 3'd0, 2'd0, 5'd0, 5'h15, 1'b1, 1'b0, 1'b0);
      regv[18] = 5'h15;
      step(1'b1, 1'b0, 3'd0, 2'd0, 5'd0, regv[eslot], 1'b1, 1'b1, 1'b0);
      // invalid channel
      step(1'b1, 1'b1, 3'd3, 2'd0, 5'h1F, regv[eslot], 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 3'd0, 2'd0, 5'd0, regv[eslot], 1'b0, 1'b0, 1'b1);
      // reset during a pending write: ch2 op3 -> target 20, captured at slot 10
      while (eslot != 5'd10) run(1'b0);
      step(1'b1, 1'b1, 3'd2, 2'd3, 5'h07, regv[eslot], 1'b0, 1'b0, 1'b0);
      while (eslot != 5'd16) run(1'b1);
      rst = 1'b1;
      eslot = 5'd0;
      step(1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 24; i++)
         step(1'b1, 1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      foreach (regv[i]) regv[i] = 5'd0;
      while (eslot != 5'd22) run(1'b0);
      @(negedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
